multi_channel_sink: RTL and testbench

- Parametrised, multi-channel traffic sink. It terminates NUM_CH NoC delivery channels and captures the last accepted word per channel.
- Counts accepted words per channel over a programmable sampling window and publishes per-channel throughput.
- Generates configurable back-pressure (none, pseudo-random or periodic) so routers can be stress-tested.
- Sits at the network edge, behind the per-port rx deserialisers, in place of a single fixed sink.

---
 rtl/multi_channel_sink_if.sv | 14 +
 rtl/multi_channel_sink.sv | 120 ++++++++++++
 tb/tb_multi_channel_sink.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_sink_if.sv
// Delivery-channel bundle between rx deserialisers and the multi-channel sink.
// Ports: req (per-channel word valid), data (packed words, channel c at [c*WIDTH +: WIDTH]),
//        busy (per-channel back-pressure returned by the sink).
interface multi_channel_sink_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*WIDTH-1:0] data;
    logic [NUM_CH-1:0]       busy;

    modport master (output req, output data, input busy);
    modport slave  (input req, input data, output busy);
endinterface

// File: rtl/multi_channel_sink.sv
// Purpose: terminates NUM_CH delivery channels, captures the last accepted word per channel,
//          publishes per-channel throughput over a 2^WIN_LOG2-cycle window and a running total.
// Latency/backpressure: last_data one cycle after accept; busy is registered (none / LFSR / periodic).
// Ports: clk, reset (async active-low), ch (req/data in, busy out), last_data, throughput,
//        window_done, total_count, seq_err. Optional macro SINK_SEQ_CHECK_EN enables sequence checks.
module multi_channel_sink #(
    parameter int ID          = -1,
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int WIN_LOG2    = 10,
    parameter int BUSY_MODE   = 0,
    parameter int BUSY_THRESH = 64,
    parameter int BUSY_PERIOD = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    multi_channel_sink_if.slave              ch,
    output logic [NUM_CH*WIDTH-1:0]          last_data,
    output logic [NUM_CH*(WIN_LOG2+1)-1:0]   throughput,
    output logic                             window_done,
    output logic [31:0]                      total_count,
    output logic [NUM_CH-1:0]                seq_err
);
    localparam int TW = WIN_LOG2 + 1;
    localparam int PW = $clog2(BUSY_PERIOD);
    // Nine bits so a threshold of 256 means "always busy".
    localparam logic [8:0]    THRESH     = 9'(BUSY_THRESH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(BUSY_PERIOD - 1);

    // Per-channel seed, folded into 1..254 so the LFSR never locks up at zero.
    function automatic logic [7:0] lfsr_seed(input int c);
        int s;
        s = ((ID + 1) * NUM_CH + c + 1) % 255;
        if (s < 0) s = s + 255;
        if (s == 0) s = 1;
        return 8'(s);
    endfunction

    logic [NUM_CH-1:0]   acc;
    logic [7:0]          lfsr    [NUM_CH];
    logic [PW-1:0]       phase;
    logic [WIN_LOG2-1:0] wc;
    logic [TW-1:0]       running [NUM_CH];
    logic                wend;

    // busy masks req, so an unknown req on a busy channel cannot leak into the counters.
    assign acc  = ch.req & ~ch.busy;
    assign wend = &wc;

    // Back-pressure generation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch.busy <= '1;
            phase   <= '0;
            for (int c = 0; c < NUM_CH; c++) lfsr[c] <= lfsr_seed(c);
        end else begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            // Fibonacci LFSR, taps 8,6,5,4.
            for (int c = 0; c < NUM_CH; c++)
                lfsr[c] <= {lfsr[c][6:0], lfsr[c][7] ^ lfsr[c][5] ^ lfsr[c][4] ^ lfsr[c][3]};
            case (BUSY_MODE)
                1: for (int c = 0; c < NUM_CH; c++) ch.busy[c] <= ({1'b0, lfsr[c]} < THRESH);
                2: ch.busy <= {NUM_CH{phase == PHASE_LAST}};
                default: ch.busy <= '0;
            endcase
        end
    end

    // Capture, windowed throughput and running total.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wc          <= '0;
            window_done <= 1'b0;
            total_count <= '0;
            last_data   <= '0;
            throughput  <= '0;
            for (int c = 0; c < NUM_CH; c++) running[c] <= '0;
        end else begin
            wc          <= wc + 1'b1;
            window_done <= wend;
            total_count <= total_count + 32'($countones(acc));
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) last_data[c*WIDTH +: WIDTH] <= ch.data[c*WIDTH +: WIDTH];
                if (wend) begin
                    // Final-cycle accept is folded into the published count.
                    throughput[c*TW +: TW] <= running[c] + TW'(acc[c]);
                    running[c]             <= '0;
                end else begin
                    running[c] <= running[c] + TW'(acc[c]);
                end
            end
        end
    end

`ifdef SINK_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_val [NUM_CH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_err <= '0;
            for (int c = 0; c < NUM_CH; c++) exp_val[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) begin
                    $display("%0t sink %0d ch %0d accept %0h", $time, ID, c, ch.data[c*WIDTH +: WIDTH]);
                    if (ch.data[c*WIDTH +: WIDTH] != exp_val[c]) begin
                        seq_err[c] <= 1'b1;
                        $display("%0t sink %0d ch %0d sequence error: got %0h expected %0h",
                                 $time, ID, c, ch.data[c*WIDTH +: WIDTH], exp_val[c]);
                    end
                    // Resynchronise on the received value so one gap flags once.
                    exp_val[c] <= ch.data[c*WIDTH +: WIDTH] + 1'b1;
                end
            end
        end
    end
`else
    assign seq_err = '0;
`endif
endmodule

// File: tb/tb_multi_channel_sink.sv
// Directed bench for multi_channel_sink: five instances cover busy modes 0, 1 (thresholds 0, 32, 256)
// and 2, sharing clock and reset. Inputs change and outputs are sampled on the falling edge.
// Cycle k counts falling edges after reset release; wc equals k mod 16 in cycle k.
module tb_multi_channel_sink;
    localparam int W  = 8;
    localparam int WL = 4;
    localparam int TW = WL + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    multi_channel_sink_if #(.NUM_CH(4), .WIDTH(W)) bus0  ();
    multi_channel_sink_if #(.NUM_CH(4), .WIDTH(W)) bus2  ();
    multi_channel_sink_if #(.NUM_CH(4), .WIDTH(W)) bus1a ();
    multi_channel_sink_if #(.NUM_CH(4), .WIDTH(W)) bus1b ();
    multi_channel_sink_if #(.NUM_CH(1), .WIDTH(W)) bus1c ();

    logic [4*W-1:0]  ld0, ld2, ld1a, ld1b;
    logic [W-1:0]    ld1c;
    logic [4*TW-1:0] tp0, tp2, tp1a, tp1b;
    logic [TW-1:0]   tp1c;
    logic            wd0, wd2, wd1a, wd1b, wd1c;
    logic [31:0]     tc0, tc2, tc1a, tc1b, tc1c;
    logic [3:0]      se0, se2, se1a, se1b;
    logic            se1c;

    multi_channel_sink #(.ID(-1), .NUM_CH(4), .WIDTH(W), .WIN_LOG2(WL), .BUSY_MODE(0)) u0 (
        .clk(clk), .reset(reset), .ch(bus0), .last_data(ld0), .throughput(tp0),
        .window_done(wd0), .total_count(tc0), .seq_err(se0));
    multi_channel_sink #(.ID(-1), .NUM_CH(4), .WIDTH(W), .WIN_LOG2(WL), .BUSY_MODE(2), .BUSY_PERIOD(4)) u2 (
        .clk(clk), .reset(reset), .ch(bus2), .last_data(ld2), .throughput(tp2),
        .window_done(wd2), .total_count(tc2), .seq_err(se2));
    multi_channel_sink #(.ID(-1), .NUM_CH(4), .WIDTH(W), .WIN_LOG2(WL), .BUSY_MODE(1), .BUSY_THRESH(0)) u1a (
        .clk(clk), .reset(reset), .ch(bus1a), .last_data(ld1a), .throughput(tp1a),
        .window_done(wd1a), .total_count(tc1a), .seq_err(se1a));
    multi_channel_sink #(.ID(-1), .NUM_CH(4), .WIDTH(W), .WIN_LOG2(WL), .BUSY_MODE(1), .BUSY_THRESH(256)) u1b (
        .clk(clk), .reset(reset), .ch(bus1b), .last_data(ld1b), .throughput(tp1b),
        .window_done(wd1b), .total_count(tc1b), .seq_err(se1b));
    multi_channel_sink #(.ID(-1), .NUM_CH(1), .WIDTH(W), .WIN_LOG2(WL), .BUSY_MODE(1), .BUSY_THRESH(32)) u1c (
        .clk(clk), .reset(reset), .ch(bus1c), .last_data(ld1c), .throughput(tp1c),
        .window_done(wd1c), .total_count(tc1c), .seq_err(se1c));

    task automatic clear_inputs();
        bus0.req = '0;  bus0.data = '0;
        bus2.req = '0;  bus2.data = '0;
        bus1a.req = '0; bus1a.data = '0;
        bus1b.req = '0; bus1b.data = '0;
        bus1c.req = '0; bus1c.data = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus0.busy !== 4'hF) begin bad++; $display("FAIL reset_busy got=%h want=f", bus0.busy); end
        total++; if (ld0 !== '0) begin bad++; $display("FAIL reset_last_data got=%h want=0", ld0); end
        total++; if (tp0 !== '0) begin bad++; $display("FAIL reset_throughput got=%h want=0", tp0); end
        total++; if (wd0 !== 1'b0) begin bad++; $display("FAIL reset_window_done got=%b want=0", wd0); end
        total++; if (tc0 !== 32'd0) begin bad++; $display("FAIL reset_total got=%0d want=0", tc0); end
        total++; if (se0 !== 4'h0) begin bad++; $display("FAIL reset_seq_err got=%h want=0", se0); end
        total++; if (bus2.busy !== 4'hF) begin bad++; $display("FAIL reset_busy_mode2 got=%h want=f", bus2.busy); end
        reset = 1'b1;
        cyc = 0;
        total++; if (bus0.busy !== 4'hF) begin bad++; $display("FAIL release_cycle0_busy got=%h want=f", bus0.busy); end
        step();
        total++; if (bus0.busy !== 4'h0) begin bad++; $display("FAIL release_cycle1_busy got=%h want=0", bus0.busy); end
    endtask

    // Full-rate traffic for 32 cycles, then a single accept on the last window cycle.
    task automatic test_window_mode0();
        logic [W-1:0] v;
        reset_dut();
        for (int k = 0; k <= 64; k++) begin
            if (k > 0) step();
            if (k >= 1) begin
                total++;
                if (wd0 !== (k == 16 || k == 32 || k == 48 || k == 64)) begin
                    bad++; $display("FAIL window_done cyc=%0d got=%b", k, wd0);
                end
            end
            if (k == 1) begin
                total++; if (bus0.busy !== 4'h0) begin bad++; $display("FAIL m0_busy got=%h want=0", bus0.busy); end
            end
            if (k == 10) begin
                total++; if (tc0 !== 32'd36) begin bad++; $display("FAIL m0_total_c10 got=%0d want=36", tc0); end
            end
            if (k == 16) for (int c = 0; c < 4; c++) begin
                total++; if (tp0[c*TW +: TW] !== 5'd15) begin bad++; $display("FAIL m0_tp_partial ch=%0d got=%0d want=15", c, tp0[c*TW +: TW]); end
            end
            if (k == 32) begin
                for (int c = 0; c < 4; c++) begin
                    v = 8'(124 + c);
                    total++; if (tp0[c*TW +: TW] !== 5'd16) begin bad++; $display("FAIL m0_tp_full ch=%0d got=%0d want=16", c, tp0[c*TW +: TW]); end
                    total++; if (ld0[c*W +: W] !== v) begin bad++; $display("FAIL m0_last_data ch=%0d got=%h want=%h", c, ld0[c*W +: W], v); end
                end
                total++; if (tc0 !== 32'd124) begin bad++; $display("FAIL m0_total_c32 got=%0d want=124", tc0); end
            end
            if (k == 48) begin
                total++; if (tp0[0 +: TW] !== 5'd1) begin bad++; $display("FAIL final_cycle_tp got=%0d want=1", tp0[0 +: TW]); end
                total++; if (tp0[TW +: TW] !== 5'd0) begin bad++; $display("FAIL final_cycle_tp_ch1 got=%0d want=0", tp0[TW +: TW]); end
                total++; if (ld0[0 +: W] !== 8'hA5) begin bad++; $display("FAIL final_cycle_ld got=%h want=a5", ld0[0 +: W]); end
                total++; if (ld0[W +: W] !== 8'd125) begin bad++; $display("FAIL hold_ld_ch1 got=%h want=7d", ld0[W +: W]); end
            end
            if (k == 64) begin
                total++; if (tp0[0 +: TW] !== 5'd0) begin bad++; $display("FAIL running_cleared got=%0d want=0", tp0[0 +: TW]); end
                total++; if (tc0 !== 32'd125) begin bad++; $display("FAIL m0_total_c64 got=%0d want=125", tc0); end
            end
            bus0.req = (k < 32) ? 4'hF : ((k == 47) ? 4'h1 : 4'h0);
            bus0.data = '0;
            if (k < 32) for (int c = 0; c < 4; c++) bus0.data[c*W +: W] = 8'(k * 4 + c);
            if (k == 47) bus0.data[0 +: W] = 8'hA5;
        end
        bus0.req = '0;
    endtask

    // Periodic busy: busy is high in cycles that are multiples of 4.
    task automatic test_periodic_busy();
        logic [W-1:0] v;
        reset_dut();
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) step();
            if (k >= 1) begin
                total++; if (bus2.busy[0] !== (k % 4 == 0)) begin bad++; $display("FAIL m2_busy cyc=%0d got=%b", k, bus2.busy[0]); end
                if (k == 1) v = 8'h00;
                else if ((k - 1) % 4 == 0) v = 8'(8'h40 + k - 2);
                else v = 8'(8'h40 + k - 1);
                total++; if (ld2[0 +: W] !== v) begin bad++; $display("FAIL m2_last_data cyc=%0d got=%h want=%h", k, ld2[0 +: W], v); end
            end
            if (k == 16 || k == 32) begin
                total++; if (tp2[0 +: TW] !== 5'd12) begin bad++; $display("FAIL m2_tp cyc=%0d got=%0d want=12", k, tp2[0 +: TW]); end
            end
            if (k == 32) begin
                total++; if (tc2 !== 32'd24) begin bad++; $display("FAIL m2_total got=%0d want=24", tc2); end
            end
            bus2.req = 4'b0001;
            bus2.data[0 +: W] = 8'(8'h40 + k);
        end
        bus2.req = '0;
    endtask

    // Thresholds 0 and 256 are the never/always extremes; threshold 32 follows the seed-1 LFSR
    // sequence 01,02,04,08,11,23,47,8e,1c giving busy 1,1,1,1,1,0,0,0,1 in cycles 1..9.
    task automatic test_lfsr_busy();
        logic [8:0] lfsr_busy;
        lfsr_busy = 9'b1_0001_1111;
        reset_dut();
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) step();
            if (k >= 1) begin
                total++; if (bus1a.busy !== 4'h0) begin bad++; $display("FAIL m1_thresh0_busy cyc=%0d got=%h want=0", k, bus1a.busy); end
                total++; if (bus1b.busy !== 4'hF) begin bad++; $display("FAIL m1_thresh256_busy cyc=%0d got=%h want=f", k, bus1b.busy); end
            end
            if (k >= 1 && k <= 9) begin
                total++; if (bus1c.busy !== lfsr_busy[k-1]) begin bad++; $display("FAIL m1_lfsr_busy cyc=%0d got=%b want=%b", k, bus1c.busy, lfsr_busy[k-1]); end
            end
            if (k == 16) for (int c = 0; c < 4; c++) begin
                total++; if (tp1a[c*TW +: TW] !== 5'd15) begin bad++; $display("FAIL m1_thresh0_tp ch=%0d got=%0d want=15", c, tp1a[c*TW +: TW]); end
                total++; if (tp1b[c*TW +: TW] !== 5'd0) begin bad++; $display("FAIL m1_thresh256_tp ch=%0d got=%0d want=0", c, tp1b[c*TW +: TW]); end
            end
            if (k == 32) begin
                total++; if (tc1a !== 32'd124) begin bad++; $display("FAIL m1_thresh0_total got=%0d want=124", tc1a); end
                total++; if (tc1b !== 32'd0) begin bad++; $display("FAIL m1_thresh256_total got=%0d want=0", tc1b); end
            end
            bus1a.req = 4'hF;
            bus1b.req = 4'hF;
            bus1c.req = 1'b1;
        end
        clear_inputs();
    endtask

    // Reset at wc=7 with five accepts pending; the partial window must vanish.
    task automatic test_mid_reset();
        reset_dut();
        for (int k = 0; k <= 23; k++) begin
            if (k > 0) step();
            if (k == 16) begin
                total++; if (tp0[0 +: TW] !== 5'd15) begin bad++; $display("FAIL pre_reset_tp got=%0d want=15", tp0[0 +: TW]); end
            end
            bus0.req  = ((k >= 1 && k <= 15) || (k >= 18 && k <= 22)) ? 4'h1 : 4'h0;
            bus0.data = 32'(k);
        end
        reset = 1'b0;
        #1;
        total++; if (bus0.busy !== 4'hF) begin bad++; $display("FAIL mid_reset_busy got=%h want=f", bus0.busy); end
        total++; if (tp0 !== '0) begin bad++; $display("FAIL mid_reset_tp got=%h want=0", tp0); end
        total++; if (ld0 !== '0) begin bad++; $display("FAIL mid_reset_ld got=%h want=0", ld0); end
        total++; if (tc0 !== 32'd0) begin bad++; $display("FAIL mid_reset_total got=%0d want=0", tc0); end
        total++; if (wd0 !== 1'b0) begin bad++; $display("FAIL mid_reset_wd got=%b want=0", wd0); end
        bus0.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) step();
            if (k == 16) begin
                total++; if (tp0[0 +: TW] !== 5'd5) begin bad++; $display("FAIL post_reset_tp got=%0d want=5", tp0[0 +: TW]); end
                total++; if (wd0 !== 1'b1) begin bad++; $display("FAIL post_reset_wd got=%b want=1", wd0); end
            end
            if (k == 17) begin
                total++; if (tc0 !== 32'd5) begin bad++; $display("FAIL post_reset_total got=%0d want=5", tc0); end
            end
            bus0.req = (k >= 5 && k <= 9) ? 4'h1 : 4'h0;
        end
        bus0.req = '0;
    endtask

`ifdef SINK_SEQ_CHECK_EN
    // ch1 skips from 2 to 4; ch0 wraps 255 -> 0 cleanly.
    task automatic test_seq_check();
        logic [W-1:0] s1 [4];
        s1[0] = 8'd0; s1[1] = 8'd1; s1[2] = 8'd2; s1[3] = 8'd4;
        reset_dut();
        for (int k = 0; k <= 258; k++) begin
            if (k > 0) step();
            if (k == 4) begin
                total++; if (se0[1] !== 1'b0) begin bad++; $display("FAIL seq_before_gap got=%b want=0", se0[1]); end
            end
            if (k == 5 || k == 258) begin
                total++; if (se0[1] !== 1'b1) begin bad++; $display("FAIL seq_gap cyc=%0d got=%b want=1", k, se0[1]); end
            end
            if (k == 258) begin
                total++; if (se0[0] !== 1'b0) begin bad++; $display("FAIL seq_wrap got=%b want=0", se0[0]); end
            end
            bus0.req[0] = (k >= 1 && k <= 257);
            bus0.data[0 +: W] = 8'(k - 1);
            bus0.req[1] = (k >= 1 && k <= 4);
            if (k >= 1 && k <= 4) bus0.data[W +: W] = s1[k-1];
        end
        bus0.req = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_window_mode0();
        test_periodic_busy();
        test_lfsr_busy();
        test_mid_reset();
`ifdef SINK_SEQ_CHECK_EN
        test_seq_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
